// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and helpers for the VGA sync generator.
// The defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_timing_pkg;

  localparam int unsigned POS_W   = 10;
  localparam int unsigned POS_MAX = 1 << POS_W;
  localparam int unsigned FRAME_W = 8;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam bit          DEF_SYNC_ACTIVE_HIGH = 1'b0;

  function automatic int unsigned h_total(input int unsigned visible, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return visible + front + sync + back;
  endfunction

  function automatic int unsigned v_total(input int unsigned visible, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster timing bus between the sync generator and the pattern/colour stage.
// The generator is the master: it receives the advance enable and drives position and flags.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic               ena;
  logic [POS_W-1:0]   hpos;
  logic [POS_W-1:0]   vpos;
  logic               hsync;
  logic               vsync;
  logic               visible;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_count;

  modport master (
    input  ena,
    output hpos, vpos, hsync, vsync, visible, line_start, frame_start, frame_count
  );

  modport slave (
    output ena,
    input  hpos, vpos, hsync, vsync, visible, line_start, frame_start, frame_count
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrap counter plus range flags decoded from its next value,
// so the owner can register flags that line up with the registered count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL      = 800,
  parameter int unsigned VISIBLE    = 640,
  parameter int unsigned SYNC_START = 656,
  parameter int unsigned SYNC_END   = 752
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             inc,
  output logic [POS_W-1:0] count,
  output logic             wrap,
  output logic             in_sync,
  output logic             in_visible
);

  localparam logic [POS_W-1:0] LAST = POS_W'(TOTAL - 1);

  if (TOTAL > POS_MAX) begin : g_total_too_big
    $error("vga_axis_counter: TOTAL exceeds counter range");
  end

  logic [POS_W-1:0] count_next;

  // wrap, in_sync and in_visible all describe the value count takes at the next edge
  always_comb begin
    wrap       = ena && inc && (count == LAST);
    count_next = count;
    if (ena && inc) begin
      count_next = wrap ? '0 : count + POS_W'(1);
    end
    in_sync    = (count_next >= POS_W'(SYNC_START)) && (count_next < POS_W'(SYNC_END));
    in_visible = count_next < POS_W'(VISIBLE);
  end

  // Reset parks on the last position so the first enabled edge lands on zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= LAST;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel position, sync pulses, visible flag, line/frame
// strobes and a free-running frame counter, all registered and mutually aligned.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE        = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT          = DEF_H_FRONT,
  parameter int unsigned H_SYNC           = DEF_H_SYNC,
  parameter int unsigned H_BACK           = DEF_H_BACK,
  parameter int unsigned V_VISIBLE        = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT          = DEF_V_FRONT,
  parameter int unsigned V_SYNC           = DEF_V_SYNC,
  parameter int unsigned V_BACK           = DEF_V_BACK,
  parameter bit          SYNC_ACTIVE_HIGH = DEF_SYNC_ACTIVE_HIGH
) (
  input  logic clk,
  input  logic rst_n,
  vga_sync_gen_if.master vga
);

  localparam int unsigned H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam bit          SYNC_IDLE = ~SYNC_ACTIVE_HIGH;

  if (H_TOTAL > POS_MAX || V_TOTAL > POS_MAX) begin : g_total_too_big
    $error("vga_sync_gen: raster totals exceed the position counter range");
  end

  logic h_wrap, h_in_sync, h_in_visible;
  logic v_wrap, v_in_sync, v_in_visible;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .VISIBLE    (H_VISIBLE),
    .SYNC_START (H_VISIBLE + H_FRONT),
    .SYNC_END   (H_VISIBLE + H_FRONT + H_SYNC)
  ) u_h_axis (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (vga.ena),
    .inc        (1'b1),
    .count      (vga.hpos),
    .wrap       (h_wrap),
    .in_sync    (h_in_sync),
    .in_visible (h_in_visible)
  );

  // The vertical axis steps once per line, on the edge the horizontal axis wraps
  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .VISIBLE    (V_VISIBLE),
    .SYNC_START (V_VISIBLE + V_FRONT),
    .SYNC_END   (V_VISIBLE + V_FRONT + V_SYNC)
  ) u_v_axis (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (vga.ena),
    .inc        (h_wrap),
    .count      (vga.vpos),
    .wrap       (v_wrap),
    .in_sync    (v_in_sync),
    .in_visible (v_in_visible)
  );

  logic               hsync_q;
  logic               vsync_q;
  logic               visible_q;
  logic               line_start_q;
  logic               frame_start_q;
  logic [FRAME_W-1:0] frame_count_q;

  // Flags are registered from next-count decodes; strobes drop whenever ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= SYNC_IDLE;
      vsync_q       <= SYNC_IDLE;
      visible_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '1;
    end else begin
      line_start_q  <= h_wrap;
      frame_start_q <= h_wrap && v_wrap;
      if (vga.ena) begin
        hsync_q   <= SYNC_ACTIVE_HIGH ? h_in_sync : ~h_in_sync;
        vsync_q   <= SYNC_ACTIVE_HIGH ? v_in_sync : ~v_in_sync;
        visible_q <= h_in_visible && v_in_visible;
        if (h_wrap && v_wrap) begin
          frame_count_q <= frame_count_q + FRAME_W'(1);
        end
      end
    end
  end

  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.visible     = visible_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a default 640x480 instance for horizontal timing
// and a shrunken-raster instance for vertical timing, frame period and counter wrap.
module tb_vga_sync_gen;

  // Shrunken raster: 16 x 12, hsync columns 10..12, vsync rows 7..8, 192 cycles per frame
  localparam int unsigned SH_VIS = 8, SH_FP = 2, SH_SY = 3, SH_BP = 3;
  localparam int unsigned SV_VIS = 6, SV_FP = 1, SV_SY = 2, SV_BP = 3;
  localparam int SH_TOT = 16;
  localparam int SFRAME = 192;

  typedef struct {
    int h; int v; int vis; int hs; int vs; int ls; int fs; int fc;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   edges;

  vga_sync_gen_if d_if ();
  vga_sync_gen_if s_if ();

  vga_sync_gen u_def (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (d_if)
  );

  vga_sync_gen #(
    .H_VISIBLE (SH_VIS), .H_FRONT (SH_FP), .H_SYNC (SH_SY), .H_BACK (SH_BP),
    .V_VISIBLE (SV_VIS), .V_FRONT (SV_FP), .V_SYNC (SV_SY), .V_BACK (SV_BP),
    .SYNC_ACTIVE_HIGH (1'b0)
  ) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic get_def(output vec_t a);
    a.h = int'(d_if.hpos); a.v = int'(d_if.vpos); a.vis = int'(d_if.visible);
    a.hs = int'(d_if.hsync); a.vs = int'(d_if.vsync); a.ls = int'(d_if.line_start);
    a.fs = int'(d_if.frame_start); a.fc = int'(d_if.frame_count);
  endtask

  task automatic get_small(output vec_t a);
    a.h = int'(s_if.hpos); a.v = int'(s_if.vpos); a.vis = int'(s_if.visible);
    a.hs = int'(s_if.hsync); a.vs = int'(s_if.vsync); a.ls = int'(s_if.line_start);
    a.fs = int'(s_if.frame_start); a.fc = int'(s_if.frame_count);
  endtask

  task automatic cmp(input string nm, input vec_t a, input vec_t e);
    chk({nm, ".hpos"}, a.h, e.h);
    chk({nm, ".vpos"}, a.v, e.v);
    chk({nm, ".visible"}, a.vis, e.vis);
    chk({nm, ".hsync"}, a.hs, e.hs);
    chk({nm, ".vsync"}, a.vs, e.vs);
    chk({nm, ".line_start"}, a.ls, e.ls);
    chk({nm, ".frame_start"}, a.fs, e.fs);
    chk({nm, ".frame_count"}, a.fc, e.fc);
  endtask

  task automatic check_def(input string nm, input vec_t e);
    vec_t a;
    get_def(a);
    cmp(nm, a, e);
  endtask

  task automatic check_small(input string nm, input vec_t e);
    vec_t a;
    get_small(a);
    cmp(nm, a, e);
  endtask

  vec_t dv [12];
  vec_t sv [14];
  vec_t def_rst, small_rst;

  initial begin
    int target;
    int pulses;

    checks   = 0;
    failures = 0;
    edges    = 0;

    //            h    v  vis hs vs ls fs fc
    def_rst   = '{799, 524, 0, 1, 1, 0, 0, 255};
    small_rst = '{15,  11,  0, 1, 1, 0, 0, 255};

    dv[0]  = '{0,   0, 1, 1, 1, 1, 1, 0};
    dv[1]  = '{1,   0, 1, 1, 1, 0, 0, 0};
    dv[2]  = '{639, 0, 1, 1, 1, 0, 0, 0};
    dv[3]  = '{640, 0, 0, 1, 1, 0, 0, 0};
    dv[4]  = '{655, 0, 0, 1, 1, 0, 0, 0};
    dv[5]  = '{656, 0, 0, 0, 1, 0, 0, 0};
    dv[6]  = '{751, 0, 0, 0, 1, 0, 0, 0};
    dv[7]  = '{752, 0, 0, 1, 1, 0, 0, 0};
    dv[8]  = '{799, 0, 0, 1, 1, 0, 0, 0};
    dv[9]  = '{0,   1, 1, 1, 1, 1, 0, 0};
    dv[10] = '{1,   1, 1, 1, 1, 0, 0, 0};
    dv[11] = '{640, 1, 0, 1, 1, 0, 0, 0};

    sv[0]  = '{0,  0, 1, 1, 1, 1, 1, 0};
    sv[1]  = '{7,  5, 1, 1, 1, 0, 0, 0};
    sv[2]  = '{8,  5, 0, 1, 1, 0, 0, 0};
    sv[3]  = '{9,  5, 0, 1, 1, 0, 0, 0};
    sv[4]  = '{10, 5, 0, 0, 1, 0, 0, 0};
    sv[5]  = '{12, 5, 0, 0, 1, 0, 0, 0};
    sv[6]  = '{13, 5, 0, 1, 1, 0, 0, 0};
    sv[7]  = '{0,  6, 0, 1, 1, 1, 0, 0};
    sv[8]  = '{15, 6, 0, 1, 1, 0, 0, 0};
    sv[9]  = '{0,  7, 0, 1, 0, 1, 0, 0};
    sv[10] = '{12, 7, 0, 0, 0, 0, 0, 0};
    sv[11] = '{13, 8, 0, 1, 0, 0, 0, 0};
    sv[12] = '{0,  9, 0, 1, 1, 1, 0, 0};
    sv[13] = '{15, 11, 0, 1, 1, 0, 0, 0};

    // Reset with ena already high, then release between edges
    rst_n    = 1'b0;
    d_if.ena = 1'b1;
    s_if.ena = 1'b1;
    tick();
    tick();
    check_def("def_reset", def_rst);
    check_small("small_reset", small_rst);
    rst_n = 1'b1;
    edges = 0;

    // Horizontal sweep on the default raster
    for (int i = 0; i < 12; i++) begin
      target = dv[i].v * 800 + dv[i].h + 1;
      while (edges < target) tick();
      check_def($sformatf("def[%0d]", i), dv[i]);
    end

    // Freeze at hpos=655 for 37 cycles, then step into the hsync pulse
    target = 1 * 800 + 655 + 1;
    while (edges < target) tick();
    d_if.ena = 1'b0;
    for (int i = 0; i < 37; i++) begin
      tick();
      check_def($sformatf("freeze[%0d]", i), '{655, 1, 0, 1, 1, 0, 0, 0});
    end
    d_if.ena = 1'b1;
    tick();
    check_def("unfreeze", '{656, 1, 0, 0, 1, 0, 0, 0});

    // Restart both instances; vertical sweep on the shrunken raster
    rst_n = 1'b0;
    tick();
    check_small("small_reset2", small_rst);
    rst_n = 1'b1;
    edges = 0;
    for (int i = 0; i < 14; i++) begin
      target = sv[i].v * SH_TOT + sv[i].h + 1;
      while (edges < target) tick();
      check_small($sformatf("small[%0d]", i), sv[i]);
    end

    // Frame period: next frame_start exactly one frame after the first
    tick();
    check_small("frame1", '{0, 0, 1, 1, 1, 1, 1, 1});
    pulses = 0;
    repeat (SFRAME - 1) begin
      tick();
      pulses += int'(s_if.frame_start);
    end
    chk("frame_quiet", pulses, 0);
    tick();
    check_small("frame2", '{0, 0, 1, 1, 1, 1, 1, 2});

    // frame_count wrap 255 -> 0
    repeat (253 * SFRAME) tick();
    check_small("frame255", '{0, 0, 1, 1, 1, 1, 1, 255});
    repeat (SFRAME) tick();
    check_small("frame_wrap", '{0, 0, 1, 1, 1, 1, 1, 0});

    // ena low on a line/frame start edge kills the strobes but holds position
    s_if.ena = 1'b0;
    tick();
    check_small("strobe_kill", '{0, 0, 1, 1, 1, 0, 0, 0});
    s_if.ena = 1'b1;
    tick();
    check_small("strobe_resume", '{1, 0, 1, 1, 1, 0, 0, 0});

    // Async reset in the middle of both sync pulses, no clock edge involved
    repeat (138) tick();
    check_small("pre_reset", '{11, 8, 0, 0, 0, 0, 0, 0});
    #2;
    rst_n = 1'b0;
    #1;
    check_small("async_small", small_rst);
    check_def("async_def", def_rst);
    tick();
    check_small("held_reset", small_rst);
    rst_n = 1'b1;
    tick();
    check_small("restart_small", '{0, 0, 1, 1, 1, 1, 1, 0});
    check_def("restart_def", '{0, 0, 1, 1, 1, 1, 1, 0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Raster timing generator feeding the pattern/colour stage inside the TinyVGA demo wrapper.
- Produces the pixel position plus hsync, vsync and visible-region flags, all registered and mutually aligned.
- Also produces line and frame strobes and a free-running frame counter for animation.
- The downstream stage computes RGB from hpos/vpos/frame_count and packs the result with hsync/vsync onto uo_out.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE_HIGH, 0, 0 = sync pulses drive low (VGA 640x480 standard)

Ports:
clk  input  1  pixel clock (25.175 MHz nominal)
rst_n  input  1  asynchronous active-low reset
ena  input  1  advance enable; low = freeze all state
hpos  output  10  current column, 0..H_TOTAL-1
vpos  output  10  current row, 0..V_TOTAL-1
hsync  output  1  horizontal sync, polarity per SYNC_ACTIVE_HIGH
vsync  output  1  vertical sync, polarity per SYNC_ACTIVE_HIGH
visible  output  1  high when hpos<H_VISIBLE and vpos<V_VISIBLE
line_start  output  1  one-cycle strobe when hpos==0
frame_start  output  1  one-cycle strobe when hpos==0 and vpos==0
frame_count  output  8  frame counter, wraps modulo 256

Behaviour:
- Derived constants: H_TOTAL = sum of the four H params (800); V_TOTAL = sum of the four V params (525). Counter width is 10 bits; elaboration fails if either total exceeds 1024.
- Reset (rst_n low, asynchronous) sets:
  - hpos = H_TOTAL-1 (799), vpos = V_TOTAL-1 (524)
  - hsync and vsync inactive; visible = 0; line_start = 0; frame_start = 0
  - frame_count = 8'hFF
- On each rising clk edge with ena=1:
  - hpos increments; hpos==H_TOTAL-1 wraps to 0.
  - vpos increments only when hpos wraps; vpos==V_TOTAL-1 wraps to 0 at the same edge that hpos wraps.
  - frame_count increments by 1, mod 256, on the edge where (hpos,vpos) becomes (0,0).
  - The first enabled edge after reset therefore yields (0,0), frame_start=1, frame_count=0.
- Output alignment:
  - All outputs are flops, computed from the next counter values, so each flag describes the hpos/vpos presented in the same cycle.
  - Latency from counter to flag is zero cycles; there is no combinational path from counters to outputs.
- Flag ranges:
  - hsync active iff H_VISIBLE+H_FRONT <= hpos < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vsync active iff V_VISIBLE+V_FRONT <= vpos < V_VISIBLE+V_FRONT+V_SYNC (490..491), for every hpos in those rows.
- ena=0: counters, hsync, vsync, visible and frame_count hold. line_start and frame_start are forced to 0 and re-assert only on an enabled edge that reaches hpos==0.
- Reset asserted mid-frame: all state returns to reset values immediately, with no clock needed; the sequence restarts as above on release.
- Frame period with ena tied high: exactly H_TOTAL*V_TOTAL = 420000 cycles between frame_start pulses.

Decomposition:
- Package vga_timing_pkg holds:
  - default timing constants for 640x480@60
  - derived H_TOTAL and V_TOTAL functions
  - position width localparam (10)
- One sub-module, vga_axis_counter, is natural: a wrap counter with parameters TOTAL, SYNC_START and SYNC_END, inputs inc and ena, outputs count, wrap, in_sync and in_visible. It is instantiated once for the horizontal axis and once for the vertical axis (vertical inc = horizontal wrap).

Test Plan:
- Reset then release with ena=1 -> before the first edge hpos=799, vpos=524, visible=0, hsync=vsync=1. After the first edge hpos=0, vpos=0, visible=1, line_start=1, frame_start=1, frame_count=0.
- Horizontal sweep -> visible falls at hpos=640; hsync goes low at hpos=656 and stays low through 751, high again at 752; at 799->0, vpos goes 0->1 and line_start pulses for exactly one cycle.
- Vertical sweep -> visible stays 0 for all of rows 480..524; vsync is low for every cycle with vpos 490 or 491, high elsewhere.
- Run 420000 enabled cycles after the first frame_start -> next frame_start lands exactly there with frame_count=1; run 256 frames -> frame_count wraps 255->0.
- Hold ena=0 for 37 cycles at hpos=655 -> all outputs frozen, strobes 0. The first enabled edge gives hpos=656 with hsync low.
- Assert rst_n low asynchronously at hpos=700, vpos=491 -> outputs take reset values without a clock edge; on release the frame restarts with frame_count=0.
